// File: rtl/axi_rd_rr_arbiter.sv
// Two-requester round-robin arbiter for the shared AXI AR/R read channels.
// AR IDs carry the requester index as MSB; R beats are routed back by it.
module axi_rd_rr_arbiter #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          s_ar_valid,
    output logic [1:0]          s_ar_ready,
    input  logic [2*ID_W-1:0]   s_ar_id,
    input  logic [2*ADDR_W-1:0] s_ar_addr,
    input  logic [15:0]         s_ar_len,
    input  logic [5:0]          s_ar_size,
    input  logic [3:0]          s_ar_burst,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ID_W:0]       m_ar_id,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    output logic [1:0]          m_ar_burst,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [ID_W:0]       m_r_id,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic [1:0]          m_r_resp,
    input  logic                m_r_last,
    output logic [1:0]          s_r_valid,
    input  logic [1:0]          s_r_ready,
    output logic [ID_W-1:0]     s_r_id,
    output logic [DATA_W-1:0]   s_r_data,
    output logic [1:0]          s_r_resp,
    output logic                s_r_last,
    output logic                rsp_err_o
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    logic          en_q;
    logic          prio_q, prio_d;
    logic          lock_q, lock_d;
    logic          gnt_q, gnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic [1:0] elig;
    logic [1:0] inc;
    logic [1:0] dec;
    logic       sel;
    logic       ar_hs;
    logic       r_sel;
    logic       r_last_hs;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = s_ar_valid[i] & (cnt_q[i] < MAX_CNT);
        end
    end

    // A stalled AR stays pinned to its requester until accepted
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = gnt_q;
        end else if (&elig) begin
            sel = prio_q;
        end else if (elig[1]) begin
            sel = 1'b1;
        end
    end

    assign m_ar_valid = en_q & elig[sel];
    assign ar_hs      = m_ar_valid & m_ar_ready;
    assign s_ar_ready = sel ? {ar_hs, 1'b0} : {1'b0, ar_hs};

    always_comb begin
        m_ar_id    = '0;
        m_ar_addr  = '0;
        m_ar_len   = '0;
        m_ar_size  = '0;
        m_ar_burst = '0;
        if (en_q) begin
            if (sel) begin
                m_ar_id    = {1'b1, s_ar_id[2*ID_W-1:ID_W]};
                m_ar_addr  = s_ar_addr[2*ADDR_W-1:ADDR_W];
                m_ar_len   = s_ar_len[15:8];
                m_ar_size  = s_ar_size[5:3];
                m_ar_burst = s_ar_burst[3:2];
            end else begin
                m_ar_id    = {1'b0, s_ar_id[ID_W-1:0]};
                m_ar_addr  = s_ar_addr[ADDR_W-1:0];
                m_ar_len   = s_ar_len[7:0];
                m_ar_size  = s_ar_size[2:0];
                m_ar_burst = s_ar_burst[1:0];
            end
        end
    end

    assign r_sel     = m_r_id[ID_W];
    assign s_r_valid = (en_q & m_r_valid) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign m_r_ready = en_q & s_r_ready[r_sel];
    assign r_last_hs = m_r_valid & m_r_ready & m_r_last;

    assign s_r_id   = en_q ? m_r_id[ID_W-1:0] : '0;
    assign s_r_data = en_q ? m_r_data : '0;
    assign s_r_resp = en_q ? m_r_resp : '0;
    assign s_r_last = en_q & m_r_last;

    assign rsp_err_o = err_q;

    always_comb begin
        prio_d = prio_q;
        lock_d = lock_q;
        gnt_d  = gnt_q;
        if (ar_hs) begin
            lock_d = 1'b0;
            prio_d = ~sel;
        end else if (m_ar_valid) begin
            lock_d = 1'b1;
            gnt_d  = sel;
        end
        // A last beat with nothing outstanding is a stray response
        err_d  = err_q | (r_last_hs & (cnt_q[r_sel] == '0));
        inc[0] = ar_hs & ~sel;
        inc[1] = ar_hs & sel;
        dec[0] = r_last_hs & ~r_sel & (cnt_q[0] != '0);
        dec[1] = r_last_hs & r_sel & (cnt_q[1] != '0);
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({inc[i], dec[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            prio_q   <= 1'b0;
            lock_q   <= 1'b0;
            gnt_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            en_q     <= 1'b1;
            prio_q   <= prio_d;
            lock_q   <= lock_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Bench for axi_rd_rr_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_axi_rd_rr_arbiter;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 4;

    logic                clk_i;
    logic                rst_ni;
    logic [1:0]          s_ar_valid;
    logic [1:0]          s_ar_ready;
    logic [2*ID_W-1:0]   s_ar_id;
    logic [2*ADDR_W-1:0] s_ar_addr;
    logic [15:0]         s_ar_len;
    logic [5:0]          s_ar_size;
    logic [3:0]          s_ar_burst;
    logic                m_ar_valid;
    logic                m_ar_ready;
    logic [ID_W:0]       m_ar_id;
    logic [ADDR_W-1:0]   m_ar_addr;
    logic [7:0]          m_ar_len;
    logic [2:0]          m_ar_size;
    logic [1:0]          m_ar_burst;
    logic                m_r_valid;
    logic                m_r_ready;
    logic [ID_W:0]       m_r_id;
    logic [DATA_W-1:0]   m_r_data;
    logic [1:0]          m_r_resp;
    logic                m_r_last;
    logic [1:0]          s_r_valid;
    logic [1:0]          s_r_ready;
    logic [ID_W-1:0]     s_r_id;
    logic [DATA_W-1:0]   s_r_data;
    logic [1:0]          s_r_resp;
    logic                s_r_last;
    logic                rsp_err_o;

    logic [ID_W-1:0]   id    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [7:0]        len   [2];
    logic [2:0]        size  [2];
    logic [1:0]        burst [2];

    assign s_ar_id    = {id[1], id[0]};
    assign s_ar_addr  = {addr[1], addr[0]};
    assign s_ar_len   = {len[1], len[0]};
    assign s_ar_size  = {size[1], size[0]};
    assign s_ar_burst = {burst[1], burst[0]};

    axi_rd_rr_arbiter #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
        .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .rsp_err_o(rsp_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding-burst counts and arbitration bookkeeping
    bit   m_en;
    int   m_prio;
    bit   m_lock;
    int   m_held;
    int   m_cnt [2];
    bit   m_err;
    logic [1:0] acc;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_prio = 0; m_lock = 0; m_held = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0; acc = 2'b00;
    endtask

    // Called mid-cycle: compare outputs, then advance model to the next edge
    task automatic model_cycle();
        bit e [2];
        int c;
        int rs;
        logic exp_mav, exp_mrr;
        logic [1:0] exp_sar, exp_srv;
        bit rhs;
        for (int i = 0; i < 2; i++)
            e[i] = m_en && s_ar_valid[i] && (m_cnt[i] < MAX_OUT);
        c = -1;
        if (m_en) begin
            if (m_lock) c = m_held;
            else if (e[0] && e[1]) c = m_prio;
            else if (e[0]) c = 0;
            else if (e[1]) c = 1;
        end
        exp_mav = (c >= 0) && e[c];
        exp_sar = 2'b00;
        if (exp_mav && m_ar_ready) exp_sar[c] = 1'b1;
        chk("ar_hs", {m_ar_valid, s_ar_ready}, {exp_mav, exp_sar});
        if (exp_mav)
            chk("ar_fields",
                {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst},
                {c[0], id[c], addr[c], len[c], size[c], burst[c]});
        rs = int'(m_r_id[ID_W]);
        exp_srv = (m_en && m_r_valid) ? (2'b01 << rs) : 2'b00;
        exp_mrr = m_en && s_r_ready[rs];
        chk("r_hs", {s_r_valid, m_r_ready}, {exp_srv, exp_mrr});
        if (m_en)
            chk("r_fields", {s_r_id, s_r_data, s_r_resp, s_r_last},
                {m_r_id[ID_W-1:0], m_r_data, m_r_resp, m_r_last});
        chk("rsp_err", rsp_err_o, m_err);
        rhs = m_r_valid && exp_mrr && m_r_last;
        if (rhs) begin
            if (m_cnt[rs] == 0) m_err = 1;
            else m_cnt[rs]--;
        end
        if (exp_mav && m_ar_ready) begin
            m_cnt[c]++;
            m_prio = 1 - c;
            m_lock = 0;
        end else if (exp_mav) begin
            m_lock = 1;
            m_held = c;
        end
        acc = exp_sar;
        m_en = 1;
    endtask

    task automatic step();
        #4;
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        s_ar_valid = 2'b00; m_ar_ready = 1'b0;
        m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0;
        m_r_resp = 2'b00; m_r_last = 1'b0; s_r_ready = 2'b00;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic set_r(input logic v, input logic rs, input logic l,
                         input logic [1:0] rdy);
        m_r_valid = v; m_r_id = {rs, 4'h3}; m_r_last = l; s_r_ready = rdy;
    endtask

    typedef struct {
        logic [1:0] sav;
        logic       mar;
        logic       rv;
        logic       rs;
        logic       rl;
        logic [1:0] srr;
        logic       mav;
        logic       msb;
        logic [1:0] sar;
        logic       mrr;
        logic [1:0] srv;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};
        tbl[4]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[5]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[6]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};
        tbl[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};
        tbl[10] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10};
        tbl[12] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10};
        tbl[13] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10};
        tbl[14] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};

        id[0] = 4'h5; addr[0] = 64'h1000; len[0] = 8'd3; size[0] = 3'd3; burst[0] = 2'd1;
        id[1] = 4'hA; addr[1] = 64'h8000; len[1] = 8'd0; size[1] = 3'd2; burst[1] = 2'd2;
        m_r_data = '0;

        // Reset state
        rst_ni = 1'b0;
        idle_inputs();
        model_reset();
        s_ar_valid = 2'b11;
        m_ar_ready = 1'b1;
        #3;
        chk("reset_out", {m_ar_valid, s_ar_ready, m_r_ready, s_r_valid, rsp_err_o}, '0);
        @(posedge clk_i);
        #1;
        idle_inputs();
        rst_ni = 1'b1;
        step();

        // Vector table
        for (int k = 0; k < 15; k++) begin
            s_ar_valid = tbl[k].sav;
            m_ar_ready = tbl[k].mar;
            m_r_data = 64'hDEAD_0000 + 64'(k);
            set_r(tbl[k].rv, tbl[k].rs, tbl[k].rl, tbl[k].srr);
            #4;
            chk($sformatf("vec%0d", k),
                {m_ar_valid, s_ar_ready, m_r_ready, s_r_valid},
                {tbl[k].mav, tbl[k].sar, tbl[k].mrr, tbl[k].srv});
            if (tbl[k].mav)
                chk($sformatf("vec%0d_msb", k), m_ar_id[ID_W], tbl[k].msb);
            model_cycle();
            @(posedge clk_i);
            #1;
        end

        // Same-cycle AR and last-R, full limit, refill, stray response
        do_reset();
        s_ar_valid = 2'b01; m_ar_ready = 1'b1;
        step();
        step();
        set_r(1'b1, 1'b0, 1'b1, 2'b01);
        step();
        set_r(1'b0, 1'b0, 1'b0, 2'b00);
        step();
        step();
        #4;
        chk("full0_ready", s_ar_ready[0], 1'b0);
        model_cycle();
        @(posedge clk_i);
        #1;
        set_r(1'b1, 1'b0, 1'b1, 2'b01);
        step();
        set_r(1'b0, 1'b0, 1'b0, 2'b00);
        #4;
        chk("refill0_ready", s_ar_ready, 2'b01);
        model_cycle();
        @(posedge clk_i);
        #1;
        s_ar_valid = 2'b00;
        set_r(1'b1, 1'b1, 1'b1, 2'b10);
        step();
        set_r(1'b0, 1'b0, 1'b0, 2'b00);
        #4;
        chk("err_set", rsp_err_o, 1'b1);
        model_cycle();
        @(posedge clk_i);
        #1;
        repeat (3) step();
        chk("err_sticky", rsp_err_o, 1'b1);

        // Asynchronous reset while an AR is held stalled
        s_ar_valid = 2'b01; m_ar_ready = 1'b0;
        step();
        s_ar_valid = 2'b11;
        set_r(1'b1, 1'b0, 1'b0, 2'b01);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async",
            {m_ar_valid, s_ar_ready, m_r_ready, s_r_valid, rsp_err_o}, '0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m_ar_ready = 1'b1;
        set_r(1'b0, 1'b0, 1'b0, 2'b00);
        #4;
        chk("rst_first_edge", m_ar_valid, 1'b0);
        model_cycle();
        @(posedge clk_i);
        #1;
        #4;
        chk("rst_serve", {m_ar_valid, m_ar_id[ID_W], s_ar_ready}, {1'b1, 1'b0, 2'b01});
        model_cycle();
        @(posedge clk_i);
        #1;

        // Randomized traffic with AXI-compliant requesters
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(s_ar_valid[i] && !acc[i])) begin
                    s_ar_valid[i] = ($urandom_range(0, 3) != 0);
                    id[i]    = 4'($urandom);
                    addr[i]  = {$urandom, $urandom};
                    len[i]   = 8'($urandom);
                    size[i]  = 3'($urandom);
                    burst[i] = 2'($urandom);
                end
            end
            m_ar_ready = ($urandom_range(0, 2) != 0);
            m_r_valid  = ($urandom_range(0, 1) != 0);
            m_r_id     = 5'($urandom);
            m_r_data   = {$urandom, $urandom};
            m_r_resp   = 2'($urandom);
            m_r_last   = ($urandom_range(0, 2) == 0);
            s_r_ready  = 2'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
